int_trap_ctrl: RTL and testbench
================================

INT_TRAP_CTRL -- requirements
Module: int_trap_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 irq  input  4  level interrupt sources irq[0..3]; a 0->1 transition marks the source pending.
REQ-005 trap  input  1  non-maskable trap request, single-cycle pulse; sets trap pending.
REQ-006 cfg_wr  input  1  write-enable for the config register.
REQ-007 cfg_wdata  input  8  config data: bit7 GIE (global enable), bits3:0 MASK (1 = irq enabled), bits6:4 ignored.
REQ-008 instr_done  input  1  CPU is at an instruction boundary this cycle.
REQ-009 int_ack  input  1  CPU accepted int_vec and saved PC.
REQ-010 reti  input  1  CPU is executing return-from-interrupt.
REQ-011 int_req  output  1  interrupt request to the CPU.
REQ-012 int_vec  output  8  handler address; valid while int_req=1.
REQ-013 I_TRP  output  1  value for status bit 4.
REQ-014 I_TRP_en  output  1  write strobe for status bit 4.
REQ-015 cfg_rdata  output  8  {GIE, 3'b000, MASK}.
REQ-016 pending  output  5  {trap_pend, irq_pend[3:0]}.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-018 Edge detect: irq_pend[n] SHALL be set in the cycle after irq[n] is sampled 0 and then 1; trap_pend SHALL be set in the cycle after trap=1.
REQ-019 Eligible set = trap_pend OR (GIE AND (irq_pend AND MASK)); priority is trap > irq0 > irq1 > irq2 > irq3.
REQ-020 IDLE->REQ on instr_done=1 with a non-empty eligible set; in the same edge the highest-priority source SHALL be latched as the selected source.
REQ-021 REQ: int_req=1 from the cycle after the transition; int_vec SHALL be 8'hF8 for trap and 8'hF0+2n for irq n, frozen until int_ack.
REQ-022 A committed request SHALL NOT be withdrawn by later MASK/GIE writes or by higher-priority arrivals while in REQ.
REQ-023 REQ->SERVICE on int_ack=1, and in that same edge the controller SHALL: clear the selected pending bit, save GIE to gie_saved, clear GIE.
REQ-024 I_TRP_en=1 and I_TRP=1 SHALL be driven for exactly the one cycle after the REQ->SERVICE transition.
REQ-025 SERVICE: no nesting; new edges and traps SHALL only accumulate in the pending bits.
REQ-026 SERVICE->IDLE on reti=1, restoring GIE from gie_saved; I_TRP_en=1 and I_TRP=0 SHALL be driven for exactly the one following cycle.
REQ-027 reti in IDLE or REQ, and int_ack in IDLE or SERVICE, SHALL be ignored.
REQ-028 A cfg_wr SHALL update GIE/MASK on the next edge.
REQ-029 If cfg_wr coincides with int_ack, MASK SHALL take cfg_wdata, GIE SHALL be cleared (ack wins), and gie_saved SHALL take the pre-write GIE.
REQ-030 If cfg_wr coincides with reti, the GIE restore SHALL win and MASK SHALL take cfg_wdata.
REQ-031 If a set and a clear of the same pending bit coincide, the set SHALL win (bit stays 1).
REQ-032 Outside the single-cycle pulses of REQ-024 and REQ-026, I_TRP_en SHALL be 0 and I_TRP SHALL be 0.

Reset
REQ-033 While reset_=0 at a clock edge the block SHALL enter IDLE and clear pending, GIE, MASK, gie_saved, the selected source and the edge-detect history; outputs SHALL be int_req=0, int_vec=8'h00, I_TRP=0, I_TRP_en=0, cfg_rdata=8'h00, pending=5'b0.
REQ-034 Reset asserted in REQ or SERVICE SHALL abort the operation with no I_TRP_en pulse; irq lines already high at reset release SHALL NOT be treated as edges.

Verification
REQ-035 cfg_wr 8'h81, irq[0] rises, instr_done -> int_req=1, int_vec=8'hF0; int_ack -> one-cycle I_TRP_en/I_TRP=1, pending[0]=0, cfg_rdata=8'h01; reti -> one-cycle I_TRP_en=1 with I_TRP=0, cfg_rdata=8'h81.
REQ-036 GIE=1, MASK=4'hF, irq[3] and irq[1] rise together, instr_done -> int_vec=8'hF2; after reti and the next instr_done -> int_vec=8'hF6.
REQ-037 cfg_rdata=8'h00 and trap pulse, instr_done -> int_vec=8'hF8 (non-maskable).
REQ-038 In SERVICE, trap pulse and irq[0] rising -> int_req stays 0, pending=5'b10001; after reti and instr_done -> int_vec=8'hF8.
REQ-039 In REQ, cfg_wr 8'h00 -> int_vec unchanged, int_req stays 1; int_ack coincident with cfg_wr 8'h8F -> GIE=0, MASK=4'hF.
REQ-040 Reset pulse during SERVICE with irq[2] held high -> all outputs 0, no I_TRP_en pulse, pending[2] stays 0.

Source files
------------

// File: rtl/int_trap_ctrl.sv
// Interrupt / trap controller.
// Edge-detects four level interrupt lines and a single-cycle trap pulse into pending bits.
// It arbitrates at instruction boundaries (trap > irq0 > irq1 > irq2 > irq3) and presents a
// frozen vector to the CPU until it is acknowledged. While a handler runs it masks nesting
// by clearing GIE, and restores GIE on return. Each entry and return drives a one-cycle
// status-bit write.
//
// Ports:
//   clk         rising-edge clock
//   reset_      synchronous active-low reset
//   irq[3:0]    level interrupt sources; a rising edge marks a source pending
//   trap        non-maskable trap request pulse
//   cfg_wr      config write enable; cfg_wdata = {GIE, 3'bx, MASK}
//   instr_done  CPU is at an instruction boundary
//   int_ack     CPU accepted int_vec
//   reti        CPU is returning from the handler
//   int_req     interrupt request to the CPU
//   int_vec     handler address, valid while int_req = 1
//   I_TRP       value for status bit 4
//   I_TRP_en    write strobe for status bit 4
//   cfg_rdata   {GIE, 3'b000, MASK}
//   pending     {trap_pend, irq_pend[3:0]}
module int_trap_ctrl (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] irq,
  input  logic       trap,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_wdata,
  input  logic       instr_done,
  input  logic       int_ack,
  input  logic       reti,
  output logic       int_req,
  output logic [7:0] int_vec,
  output logic       I_TRP,
  output logic       I_TRP_en,
  output logic [7:0] cfg_rdata,
  output logic [4:0] pending
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  localparam logic [2:0] SelTrap = 3'd4;

  state_e     state_q, state_d;
  logic [3:0] irq_pend_q, irq_pend_d;
  logic       trap_pend_q, trap_pend_d;
  logic       gie_q, gie_d;
  logic       gie_saved_q, gie_saved_d;
  logic [3:0] mask_q, mask_d;
  logic [2:0] sel_q, sel_d;       // SelTrap or irq index
  logic [3:0] irq_hist_q;
  logic       hist_vld_q;         // low for the first cycle after reset
  logic       trp_en_q, trp_en_d;
  logic       trp_q, trp_d;

  logic [3:0] irq_rise;
  logic [3:0] irq_elig;
  logic       any_elig;
  logic [2:0] sel_pick;

  // Without valid history, lines already high at reset release must not count as edges.
  assign irq_rise = hist_vld_q ? (irq & ~irq_hist_q) : 4'b0000;
  assign irq_elig = {4{gie_q}} & irq_pend_q & mask_q;
  assign any_elig = trap_pend_q | (|irq_elig);

  always_comb begin
    sel_pick = 3'd3;
    if (trap_pend_q)      sel_pick = SelTrap;
    else if (irq_elig[0]) sel_pick = 3'd0;
    else if (irq_elig[1]) sel_pick = 3'd1;
    else if (irq_elig[2]) sel_pick = 3'd2;
  end

  always_comb begin
    state_d     = state_q;
    irq_pend_d  = irq_pend_q;
    trap_pend_d = trap_pend_q;
    gie_d       = gie_q;
    gie_saved_d = gie_saved_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    trp_en_d    = 1'b0;
    trp_d       = 1'b0;

    if (cfg_wr) begin
      gie_d  = cfg_wdata[7];
      mask_d = cfg_wdata[3:0];
    end

    unique case (state_q)
      StIdle: begin
        if (instr_done && any_elig) begin
          state_d = StReq;
          sel_d   = sel_pick;
        end
      end
      StReq: begin
        if (int_ack) begin
          state_d = StService;
          if (sel_q == SelTrap) trap_pend_d = 1'b0;
          else                  irq_pend_d[sel_q[1:0]] = 1'b0;
          // Ack overrides a coincident GIE write; the saved copy is the pre-write value.
          gie_saved_d = gie_q;
          gie_d       = 1'b0;
          trp_en_d    = 1'b1;
          trp_d       = 1'b1;
        end
      end
      StService: begin
        if (reti) begin
          state_d  = StIdle;
          gie_d    = gie_saved_q;
          trp_en_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Sets are merged last so a coincident clear of the same bit loses.
    irq_pend_d  = irq_pend_d | irq_rise;
    trap_pend_d = trap_pend_d | trap;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q     <= StIdle;
      irq_pend_q  <= 4'b0000;
      trap_pend_q <= 1'b0;
      gie_q       <= 1'b0;
      gie_saved_q <= 1'b0;
      mask_q      <= 4'b0000;
      sel_q       <= 3'd0;
      irq_hist_q  <= 4'b0000;
      hist_vld_q  <= 1'b0;
      trp_en_q    <= 1'b0;
      trp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_pend_q  <= irq_pend_d;
      trap_pend_q <= trap_pend_d;
      gie_q       <= gie_d;
      gie_saved_q <= gie_saved_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      irq_hist_q  <= irq;
      hist_vld_q  <= 1'b1;
      trp_en_q    <= trp_en_d;
      trp_q       <= trp_d;
    end
  end

  always_comb begin
    int_req = 1'b0;
    int_vec = 8'h00;
    if (state_q == StReq) begin
      int_req = 1'b1;
      int_vec = (sel_q == SelTrap) ? 8'hF8 : (8'hF0 + {4'b0000, sel_q[1:0], 1'b0});
    end
  end

  assign I_TRP     = trp_q;
  assign I_TRP_en  = trp_en_q;
  assign cfg_rdata = {gie_q, 3'b000, mask_q};
  assign pending   = {trap_pend_q, irq_pend_q};

endmodule

// File: tb/tb_int_trap_ctrl.sv
module tb_int_trap_ctrl;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic [3:0] irq = '0;
  logic       trap = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_wdata = '0;
  logic       instr_done = 1'b0;
  logic       int_ack = 1'b0;
  logic       reti = 1'b0;
  logic       int_req;
  logic [7:0] int_vec;
  logic       I_TRP;
  logic       I_TRP_en;
  logic [7:0] cfg_rdata;
  logic [4:0] pending;

  int tests = 0;
  int fails = 0;

  int_trap_ctrl dut (
    .clk        (clk),
    .reset_     (reset_),
    .irq        (irq),
    .trap       (trap),
    .cfg_wr     (cfg_wr),
    .cfg_wdata  (cfg_wdata),
    .instr_done (instr_done),
    .int_ack    (int_ack),
    .reti       (reti),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .I_TRP      (I_TRP),
    .I_TRP_en   (I_TRP_en),
    .cfg_rdata  (cfg_rdata),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Reference model: controller phase, chosen source, pending sets and config.
  localparam int PhIdle = 0;
  localparam int PhReq  = 1;
  localparam int PhSvc  = 2;
  int         m_phase = PhIdle;
  int         m_sel = 0;          // 4 = trap, else irq number
  logic [3:0] m_irqp = '0;
  logic       m_trap = 1'b0;
  logic       m_gie = 1'b0;
  logic [3:0] m_mask = '0;
  logic       m_saved = 1'b0;
  logic [3:0] m_hist = '0;
  logic       m_hist_ok = 1'b0;
  logic       m_pen = 1'b0;
  logic       m_pval = 1'b0;

  task automatic model_step();
    logic [3:0] rise;
    logic       old_gie;
    logic [3:0] old_mask;
    int         pick;
    rise   = m_hist_ok ? (irq & ~m_hist) : 4'b0000;
    m_pen  = 1'b0;
    m_pval = 1'b0;
    if (!reset_) begin
      m_phase = PhIdle; m_sel = 0; m_irqp = '0; m_trap = 1'b0; m_gie = 1'b0;
      m_mask = '0; m_saved = 1'b0; m_hist = '0; m_hist_ok = 1'b0;
      return;
    end
    old_gie  = m_gie;
    old_mask = m_mask;
    if (cfg_wr) begin
      m_gie  = cfg_wdata[7];
      m_mask = cfg_wdata[3:0];
    end
    case (m_phase)
      PhIdle: if (instr_done) begin
        pick = -1;
        if (m_trap) pick = 4;
        else for (int i = 0; i < 4; i++)
          if (pick < 0 && old_gie && m_irqp[i] && old_mask[i]) pick = i;
        if (pick >= 0) begin
          m_phase = PhReq;
          m_sel   = pick;
        end
      end
      PhReq: if (int_ack) begin
        if (m_sel == 4) m_trap = 1'b0;
        else            m_irqp[m_sel] = 1'b0;
        m_saved = old_gie;
        m_gie   = 1'b0;
        m_phase = PhSvc;
        m_pen   = 1'b1;
        m_pval  = 1'b1;
      end
      default: if (reti) begin
        m_gie   = m_saved;
        m_phase = PhIdle;
        m_pen   = 1'b1;
      end
    endcase
    m_irqp    = m_irqp | rise;
    if (trap) m_trap = 1'b1;
    m_hist    = irq;
    m_hist_ok = 1'b1;
  endtask

  // Advance one clock; outputs are then stable for sampling.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0; irq = '0; trap = 1'b0; cfg_wr = 1'b0; cfg_wdata = '0;
    instr_done = 1'b0; int_ack = 1'b0; reti = 1'b0;
    tick(); tick();
    reset_ = 1'b1;
    tick();
  endtask

  task automatic write_cfg(input logic [7:0] d);
    cfg_wr = 1'b1; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({int_req, int_vec, I_TRP, I_TRP_en, cfg_rdata, pending} !== 24'h0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b vec=%h trp=%b en=%b cfg=%h pend=%b, want all 0",
               int_req, int_vec, I_TRP, I_TRP_en, cfg_rdata, pending);
    end
  endtask

  task automatic test_basic();
    do_reset();
    write_cfg(8'h81);
    irq = 4'b0001; tick();
    tests++;
    if (pending !== 5'b00001) begin
      fails++; $display("FAIL basic_pend: got %b want 00001", pending);
    end
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    tests++;
    if (int_req !== 1'b1 || int_vec !== 8'hF0) begin
      fails++; $display("FAIL basic_req: got req=%b vec=%h want 1/F0", int_req, int_vec);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tests++;
    if ({I_TRP_en, I_TRP, int_req, pending, cfg_rdata} !== {3'b110, 5'b0, 8'h01}) begin
      fails++;
      $display("FAIL basic_ack: got en=%b trp=%b req=%b pend=%b cfg=%h want 1/1/0/00000/01",
               I_TRP_en, I_TRP, int_req, pending, cfg_rdata);
    end
    tick();
    tests++;
    if (I_TRP_en !== 1'b0 || I_TRP !== 1'b0) begin
      fails++; $display("FAIL basic_pulse_end: got en=%b trp=%b want 0/0", I_TRP_en, I_TRP);
    end
    reti = 1'b1; tick(); reti = 1'b0;
    tests++;
    if (I_TRP_en !== 1'b1 || I_TRP !== 1'b0 || cfg_rdata !== 8'h81) begin
      fails++;
      $display("FAIL basic_reti: got en=%b trp=%b cfg=%h want 1/0/81", I_TRP_en, I_TRP, cfg_rdata);
    end
    tick();
    tests++;
    if (I_TRP_en !== 1'b0) begin
      fails++; $display("FAIL basic_reti_end: got en=%b want 0", I_TRP_en);
    end
  endtask

  task automatic test_priority();
    do_reset();
    write_cfg(8'h8F);
    irq = 4'b1010; tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    tests++;
    if (int_vec !== 8'hF2) begin
      fails++; $display("FAIL prio_first: got vec=%h want F2", int_vec);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    tests++;
    if (int_req !== 1'b1 || int_vec !== 8'hF6) begin
      fails++; $display("FAIL prio_second: got req=%b vec=%h want 1/F6", int_req, int_vec);
    end
  endtask

  task automatic test_trap();
    do_reset();
    write_cfg(8'h00);
    trap = 1'b1; tick(); trap = 1'b0;
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    tests++;
    if (int_req !== 1'b1 || int_vec !== 8'hF8 || cfg_rdata !== 8'h00) begin
      fails++;
      $display("FAIL trap_nmi: got req=%b vec=%h cfg=%h want 1/F8/00", int_req, int_vec, cfg_rdata);
    end
  endtask

  task automatic test_service_accumulate();
    do_reset();
    write_cfg(8'h81);
    trap = 1'b1; tick(); trap = 1'b0;
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    trap = 1'b1; irq = 4'b0001; instr_done = 1'b1; tick(); trap = 1'b0;
    tests++;
    if (int_req !== 1'b0 || pending !== 5'b10001) begin
      fails++; $display("FAIL svc_accum: got req=%b pend=%b want 0/10001", int_req, pending);
    end
    tick(); instr_done = 1'b0;
    tests++;
    if (int_req !== 1'b0) begin
      fails++; $display("FAIL svc_no_nest: got req=%b want 0", int_req);
    end
    reti = 1'b1; tick(); reti = 1'b0;
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    tests++;
    if (int_req !== 1'b1 || int_vec !== 8'hF8) begin
      fails++; $display("FAIL svc_after_reti: got req=%b vec=%h want 1/F8", int_req, int_vec);
    end
  endtask

  task automatic test_req_commit();
    do_reset();
    write_cfg(8'h84);
    irq = 4'b0100; tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    cfg_wr = 1'b1; cfg_wdata = 8'h00; trap = 1'b1; tick(); trap = 1'b0;
    tests++;
    if (int_req !== 1'b1 || int_vec !== 8'hF4 || cfg_rdata !== 8'h00) begin
      fails++;
      $display("FAIL commit_hold: got req=%b vec=%h cfg=%h want 1/F4/00", int_req, int_vec, cfg_rdata);
    end
    cfg_wdata = 8'h8F; int_ack = 1'b1; tick(); int_ack = 1'b0; cfg_wr = 1'b0;
    tests++;
    if (cfg_rdata !== 8'h0F || I_TRP_en !== 1'b1 || pending !== 5'b10000) begin
      fails++;
      $display("FAIL commit_ack_wr: got cfg=%h en=%b pend=%b want 0F/1/10000",
               cfg_rdata, I_TRP_en, pending);
    end
    reti = 1'b1; tick(); reti = 1'b0;
    tests++;
    if (cfg_rdata !== 8'h0F) begin
      fails++; $display("FAIL commit_restore: got cfg=%h want 0F", cfg_rdata);
    end
  endtask

  task automatic test_collision();
    do_reset();
    write_cfg(8'h81);
    irq = 4'b0001; tick();
    irq = 4'b0000; tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    int_ack = 1'b1; irq = 4'b0001; tick(); int_ack = 1'b0;
    tests++;
    if (pending !== 5'b00001) begin
      fails++; $display("FAIL set_wins: got pend=%b want 00001", pending);
    end
    cfg_wr = 1'b1; cfg_wdata = 8'h02; reti = 1'b1; tick(); cfg_wr = 1'b0; reti = 1'b0;
    tests++;
    if (cfg_rdata !== 8'h82) begin
      fails++; $display("FAIL reti_wr: got cfg=%h want 82", cfg_rdata);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    write_cfg(8'h81);
    reti = 1'b1; tick(); reti = 1'b0;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tests++;
    if (I_TRP_en !== 1'b0 || cfg_rdata !== 8'h81 || int_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: got en=%b cfg=%h req=%b want 0/81/0", I_TRP_en, cfg_rdata, int_req);
    end
    irq = 4'b0001; tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    tests++;
    if (int_req !== 1'b1 || I_TRP_en !== 1'b0) begin
      fails++; $display("FAIL req_reti_ignore: got req=%b en=%b want 1/0", int_req, I_TRP_en);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    write_cfg(8'h84);
    irq = 4'b0100; tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick();
    reset_ = 1'b0; tick();
    tests++;
    if ({int_req, int_vec, I_TRP, I_TRP_en, cfg_rdata, pending} !== 24'h0) begin
      fails++;
      $display("FAIL abort_outputs: got req=%b vec=%h trp=%b en=%b cfg=%h pend=%b want all 0",
               int_req, int_vec, I_TRP, I_TRP_en, cfg_rdata, pending);
    end
    reset_ = 1'b1; tick();
    tick();
    tests++;
    if (pending !== 5'b0 || I_TRP_en !== 1'b0 || int_req !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_edge: got pend=%b en=%b req=%b want 00000/0/0", pending, I_TRP_en, int_req);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_vec;
    logic [23:0] exp_all;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset_     = ($urandom_range(59, 0) != 0);
      trap       = ($urandom_range(7, 0) == 0);
      cfg_wr     = ($urandom_range(5, 0) == 0);
      cfg_wdata  = 8'($urandom);
      instr_done = 1'($urandom_range(1, 0));
      int_ack    = ($urandom_range(2, 0) == 0);
      reti       = ($urandom_range(2, 0) == 0);
      if ($urandom_range(3, 0) == 0) irq = irq ^ (4'b0001 << $urandom_range(3, 0));
      tick();
      exp_vec = 8'h00;
      if (m_phase == PhReq) exp_vec = (m_sel == 4) ? 8'hF8 : 8'(8'hF0 + 2 * m_sel);
      exp_all = {(m_phase == PhReq), exp_vec, m_pval, m_pen, m_gie, 3'b000, m_mask,
                 m_trap, m_irqp};
      tests++;
      if ({int_req, int_vec, I_TRP, I_TRP_en, cfg_rdata, pending} !== exp_all) begin
        fails++;
        $display("FAIL random_cycle_%0d: got {req,vec,trp,en,cfg,pend}=%h want %h", n,
                 {int_req, int_vec, I_TRP, I_TRP_en, cfg_rdata, pending}, exp_all);
        break;
      end
    end
    reset_ = 1'b1; trap = 1'b0; cfg_wr = 1'b0; instr_done = 1'b0; int_ack = 1'b0; reti = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_trap();
    test_service_accumulate();
    test_req_commit();
    test_collision();
    test_ignored();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
